// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller.
// FSM state encoding, round-count presets and round-index width.
package aes_pkg;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  localparam int RIDX_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    DONE
  } state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Control bundle between launch inputs and the AES round datapath.
// master: drives start/abort/rk_valid; slave: drives enables/index/status.
interface aes_round_ctrl_if #(
  parameter int RW = 4
);

  logic          start;
  logic          abort;
  logic          rk_valid;
  logic [RW-1:0] round_idx;
  logic          load_en;
  logic          round_en;
  logic          mix_en;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, rk_valid,
    input  round_idx, load_en, round_en,
    input  mix_en, busy, done
  );

  modport slave (
    input  start, abort, rk_valid,
    output round_idx, load_en, round_en,
    output mix_en, busy, done
  );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector for a level input; rise = in & ~in_q.
// Ports: clk, rst (sync, active-high), in (level), rise (pulse).
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_q;
  logic in_d;

  always_comb in_d = in;

  // Reset to 1 so a level already high out of reset is not a rise.
  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b1;
    else     in_q <= in_d;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequences one AES encryption: key add, NR-1 full rounds, final round.
// Ports: clk, rst (sync, active-high), bus (slave side of the control bundle).
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_128,
  parameter int RW = RIDX_W
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_ctrl_if.slave  bus
);

  localparam logic [RW-1:0] LAST_FULL = RW'(NR - 1);
  localparam logic [RW-1:0] FIN_IDX   = RW'(NR);

  state_e        state_q;
  state_e        state_d;
  logic [RW-1:0] idx_q;
  logic [RW-1:0] idx_d;
  logic          start_rise;
  logic          load_en;
  logic          round_en;
  logic          mix_en;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .in   (bus.start),
    .rise (start_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load_en  = 1'b0;
    round_en = 1'b0;
    mix_en   = 1'b0;
    // Abort wins and leaves every enable low this cycle.
    if (bus.abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_rise) begin
            state_d = LOAD;
            idx_d   = '0;
          end
        end
        LOAD: begin
          load_en = bus.rk_valid;
          if (bus.rk_valid) begin
            state_d = ROUND;
            idx_d   = RW'(1);
          end
        end
        ROUND: begin
          round_en = bus.rk_valid;
          mix_en   = bus.rk_valid;
          if (bus.rk_valid) begin
            if (idx_q == LAST_FULL) begin
              state_d = FINAL;
              idx_d   = FIN_IDX;
            end else begin
              idx_d = idx_q + RW'(1);
            end
          end
        end
        FINAL: begin
          round_en = bus.rk_valid;
          if (bus.rk_valid) begin
            state_d = DONE;
            idx_d   = '0;
          end
        end
        DONE: begin
          state_d = IDLE;
          idx_d   = '0;
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign bus.round_idx = idx_q;
  assign bus.load_en   = load_en;
  assign bus.round_en  = round_en;
  assign bus.mix_en    = mix_en;
  assign bus.busy      = (state_q == LOAD) ||
                         (state_q == ROUND) ||
                         (state_q == FINAL);
  assign bus.done      = (state_q == DONE);

endmodule
